// File: rtl/axi_cache_bridge_pkg.sv
// Shared definitions for the cache-line AXI bridge: burst constants and FSM state types.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package axi_cache_bridge_pkg;

    // Every line transfer is a 4-beat, 32-bit, incrementing burst.
    localparam logic [7:0] AXI_LEN   = 8'd3;
    localparam logic [2:0] AXI_SIZE  = 3'd2;
    localparam logic [1:0] AXI_INCR  = 2'b01;
    localparam int         LINE_WORDS = 4;

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_DATA,
        R_DONE
    } rd_state_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_AW,
        W_DATA,
        W_B,
        W_DONE
    } wr_state_t;

endpackage

// File: rtl/axi_line_writer.sv
// Writes one 128-bit cache line as a 4-beat AXI burst (AW, then W beats low word first, then B).
// Latency: awvalid the cycle after accept; wr_valid pulses the cycle after the B handshake.
// Backpressure: wr_rdy only in W_IDLE; every AXI valid is held until its ready.
// Ports: clk/resetn; cache write request (wr_req/wr_addr/wr_data/wr_rdy/wr_valid);
//        busy + line_addr for read-after-write ordering; AXI AW, W and B channels.
module axi_line_writer
    import axi_cache_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID      = 4'd1,
    parameter int         BURST_WORDS = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         wr_req,
    input  logic [31:0]  wr_addr,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic         wr_valid,
    output logic         busy,
    output logic [27:0]  line_addr,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic         bvalid,
    output logic         bready
);

    localparam logic [1:0] LAST_BEAT = 2'(BURST_WORDS - 1);

    wr_state_t     state_q;
    logic [1:0]    beat_q;
    logic [27:0]   line_q;
    logic [127:0]  data_q;
    logic          unused_offset;

    // The byte offset inside the line is irrelevant: whole lines are written.
    assign unused_offset = ^wr_addr[3:0];

    assign wr_rdy    = (state_q == W_IDLE);
    assign busy      = (state_q != W_IDLE);
    assign line_addr = line_q;

    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign awaddr  = {line_q, 4'b0000};
    assign awlen   = AXI_LEN;
    assign awsize  = AXI_SIZE;
    assign awburst = AXI_INCR;
    assign wstrb   = 4'hF;
    assign wdata   = data_q[{beat_q, 5'b00000} +: 32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= W_IDLE;
            beat_q   <= 2'd0;
            line_q   <= 28'd0;
            data_q   <= 128'd0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            wlast    <= 1'b0;
            bready   <= 1'b0;
            wr_valid <= 1'b0;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (wr_req) begin
                        line_q  <= wr_addr[31:4];
                        data_q  <= wr_data;
                        awvalid <= 1'b1;
                        state_q <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        beat_q  <= 2'd0;
                        wlast   <= 1'b0;
                        state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wready) begin
                        if (beat_q == LAST_BEAT) begin
                            wvalid  <= 1'b0;
                            wlast   <= 1'b0;
                            bready  <= 1'b1;
                            state_q <= W_B;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                            // wlast rides with the beat about to be presented.
                            wlast  <= (beat_q == LAST_BEAT - 2'd1);
                        end
                    end
                end
                W_B: begin
                    if (bvalid) begin
                        bready   <= 1'b0;
                        wr_valid <= 1'b1;
                        state_q  <= W_DONE;
                    end
                end
                W_DONE: begin
                    wr_valid <= 1'b0;
                    state_q  <= W_IDLE;
                end
                default: state_q <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_cache_bridge.sv
// Bridges cache-line read/write requests onto a 32-bit AXI master with 4-beat INCR bursts.
// Latency: arvalid the cycle after a read accept; ret_valid the cycle after the rlast beat.
// Backpressure: rd_rdy/wr_rdy only when the respective FSM is idle; reads to a line with a write in flight are held off.
// Ports: clk/resetn; cache read side (rd_*/ret_*), cache write side (wr_*); AXI AR/R/AW/W/B.
module axi_cache_bridge
    import axi_cache_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID      = 4'd1,
    parameter int         BURST_WORDS = 4
) (
    input  logic         clk,
    input  logic         resetn,
    // cache read side
    input  logic         rd_req,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [127:0] ret_data,
    // cache write side
    input  logic         wr_req,
    input  logic [31:0]  wr_addr,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic         wr_valid,
    // AR
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    // R
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    // AW
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    // W
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    // B
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    rd_state_t    r_state_q;
    logic [1:0]   r_beat_q;
    logic         wr_busy;
    logic [27:0]  wr_line;
    logic         raw_block;
    logic         unused_axi;

    // Read IDs/responses are not checked; the low address nibble is dropped by line alignment.
    assign unused_axi = ^{rid, rresp, bid, bresp, rd_addr[3:0]};

    assign arid    = AXI_ID;
    assign arlen   = AXI_LEN;
    assign arsize  = AXI_SIZE;
    assign arburst = AXI_INCR;

    // Read-after-write to the same line waits for the write to finish. The second term
    // covers a write to that line being accepted in this very cycle, before it is latched.
    assign raw_block = (wr_busy && (rd_addr[31:4] == wr_line)) ||
                       (wr_req && wr_rdy && (rd_addr[31:4] == wr_addr[31:4]));
    assign rd_rdy    = (r_state_q == R_IDLE) && !raw_block;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            r_beat_q  <= 2'd0;
            araddr    <= 32'd0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            ret_valid <= 1'b0;
            ret_data  <= 128'd0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (rd_req && rd_rdy) begin
                        araddr    <= {rd_addr[31:4], 4'b0000};
                        arvalid   <= 1'b1;
                        r_beat_q  <= 2'd0;
                        r_state_q <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid   <= 1'b0;
                        rready    <= 1'b1;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid) begin
                        // Words not reached before an early rlast keep their old contents.
                        ret_data[{r_beat_q, 5'b00000} +: 32] <= rdata;
                        r_beat_q <= r_beat_q + 2'd1;
                        if (rlast) begin
                            rready    <= 1'b0;
                            ret_valid <= 1'b1;
                            r_state_q <= R_DONE;
                        end
                    end
                end
                R_DONE: begin
                    ret_valid <= 1'b0;
                    r_state_q <= R_IDLE;
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    axi_line_writer #(
        .AXI_ID      (AXI_ID),
        .BURST_WORDS (BURST_WORDS)
    ) u_writer (
        .clk       (clk),
        .resetn    (resetn),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .wr_valid  (wr_valid),
        .busy      (wr_busy),
        .line_addr (wr_line),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wid       (wid),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bvalid    (bvalid),
        .bready    (bready)
    );

endmodule

// File: tb/tb_axi_cache_bridge.sv
// Directed bench for axi_cache_bridge: line reads/writes, RAW hold-off, concurrency, reset.
// Latency: n/a.
// Backpressure: the bench toggles wready/awready to exercise valid holding.
module tb_axi_cache_bridge;

    logic         clk;
    logic         resetn;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [127:0] ret_data;
    logic         wr_req;
    logic [31:0]  wr_addr;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic         wr_valid;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [3:0]   wid;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    localparam int TMO = 200;

    axi_cache_bridge #(.AXI_ID(4'd1), .BURST_WORDS(4)) dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_rdy(wr_rdy), .wr_valid(wr_valid),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues a cache read, serves nbeats R beats from 'beats', checks the returned line.
    task automatic read_line(input string tg, input logic [31:0] addr, input logic [127:0] beats,
                             input int nbeats, input logic [127:0] exp_line,
                             output int acc_cyc, output int av_cyc);
        int n;
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = addr;
        #1;
        n = 0;
        while (!rd_rdy && n < TMO) begin @(negedge clk); #1; n++; end
        chk({tg, "_accept_timeout"}, 1'(n >= TMO), 1'b0);
        acc_cyc = cyc;
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        n = 0;
        while (!arvalid && n < TMO) begin @(negedge clk); #1; n++; end
        av_cyc = cyc;
        chk({tg, "_araddr"}, araddr, {addr[31:4], 4'b0000});
        chk({tg, "_arlen"}, arlen, 8'd3);
        n = 0;
        while (!rready && n < TMO) begin @(negedge clk); #1; n++; end
        chk({tg, "_rready_timeout"}, 1'(n >= TMO), 1'b0);
        for (int k = 0; k < nbeats; k++) begin
            rvalid = 1'b1;
            rdata  = beats[32*k +: 32];
            rlast  = (k == nbeats - 1);
            @(negedge clk);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        chk({tg, "_ret_valid"}, ret_valid, 1'b1);
        chk({tg, "_ret_data"}, ret_data, exp_line);
        @(negedge clk);
        #1;
        chk({tg, "_ret_valid_drop"}, ret_valid, 1'b0);
    endtask

    // Issues a cache write, applies wpat (LSB first) to wready, checks beats and completion.
    task automatic write_line(input string tg, input logic [31:0] addr, input logic [127:0] data,
                              input logic [4:0] wpat,
                              output int acc_cyc, output int aw_cyc, output int wrv_cyc);
        int n;
        int k;
        int i;
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_data = data;
        #1;
        n = 0;
        while (!wr_rdy && n < TMO) begin @(negedge clk); #1; n++; end
        chk({tg, "_accept_timeout"}, 1'(n >= TMO), 1'b0);
        acc_cyc = cyc;
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        n = 0;
        while (!awvalid && n < TMO) begin @(negedge clk); #1; n++; end
        aw_cyc = cyc;
        chk({tg, "_awaddr"}, awaddr, {addr[31:4], 4'b0000});
        chk({tg, "_awlen"}, awlen, 8'd3);
        k = 0;
        i = 0;
        n = 0;
        while (k < 4 && n < TMO) begin
            @(negedge clk);
            wready = (i < 5) ? wpat[i] : 1'b1;
            i++;
            #1;
            if (wvalid && wready) begin
                chk($sformatf("%s_wdata%0d", tg, k), wdata, data[32*k +: 32]);
                chk($sformatf("%s_wlast%0d", tg, k), wlast, 1'(k == 3));
                if (k == 0) chk({tg, "_wstrb"}, wstrb, 4'hF);
                k++;
            end
            n++;
        end
        chk({tg, "_beat_count"}, k, 4);
        @(negedge clk);
        wready = 1'b0;
        #1;
        n = 0;
        while (!bready && n < TMO) begin @(negedge clk); #1; n++; end
        chk({tg, "_bready_timeout"}, 1'(n >= TMO), 1'b0);
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        chk({tg, "_wr_valid"}, wr_valid, 1'b1);
        wrv_cyc = cyc;
        @(negedge clk);
        #1;
        chk({tg, "_wr_valid_drop"}, wr_valid, 1'b0);
    endtask

    initial begin
        int ra, rv, wa, wv, wd;
        logic overlap;

        resetn  = 1'b0;
        rd_req  = 1'b0; rd_addr = 32'd0;
        wr_req  = 1'b0; wr_addr = 32'd0; wr_data = 128'd0;
        arready = 1'b1; awready = 1'b1; wready = 1'b0;
        rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
        bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_ret_data", ret_data, 128'd0);
        chk("rst_ret_valid", ret_valid, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_rd_rdy", rd_rdy, 1'b1);
        chk("rst_wr_rdy", wr_rdy, 1'b1);
        chk("rst_arid", arid, 4'd1);
        chk("rst_arsize_burst", {arsize, arburst}, {3'd2, 2'b01});

        // Basic line read
        read_line("rd1", 32'h1FC0_0014, {32'h44, 32'h33, 32'h22, 32'h11}, 4,
                  128'h00000044_00000033_00000022_00000011, ra, rv);
        chk("rd1_ar_latency", rv - ra, 1);

        // Early rlast after two beats: upper words stay from the previous read
        read_line("rd_early", 32'h0000_2000, {32'hDEAD, 32'hBEEF, 32'hBB, 32'hAA}, 2,
                  128'h00000044_00000033_000000BB_000000AA, ra, rv);

        // Line write with wready toggling 1,0,1,1,1
        write_line("wr1", 32'h0000_1230, {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000},
                   5'b11101, wa, wv, wd);
        chk("wr1_aw_latency", wv - wa, 1);
        chk("wr1_awid_wid", {awid, wid}, 8'h11);

        // Same-line write and read in the same cycle: the write goes first
        overlap = 1'b0;
        fork
            write_line("raw_wr", 32'h8000_0040, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 5'b11111, wa, wv, wd);
            read_line("raw_rd", 32'h8000_0048, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 4,
                      {32'hE3, 32'hE2, 32'hE1, 32'hE0}, ra, rv);
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk); #2;
                    if (arvalid && !wr_rdy) overlap = 1'b1;
                end
            end
        join
        chk("raw_no_overlap", overlap, 1'b0);
        chk("raw_read_after_wr_valid", ra - wd, 1);

        // Different lines in the same cycle: both accepted together
        fork
            read_line("cc_rd", 32'h0000_0100, {32'h4, 32'h3, 32'h2, 32'h1}, 4,
                      {32'h4, 32'h3, 32'h2, 32'h1}, ra, rv);
            write_line("cc_wr", 32'h0000_0200, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 5'b11111, wa, wv, wd);
        join
        chk("cc_same_accept", ra - wa, 0);
        chk("cc_ar_n1", rv - ra, 1);
        chk("cc_aw_n1", wv - wa, 1);

        // Reset in the middle of a read burst while a write sits in W_AW
        @(negedge clk);
        awready = 1'b0;
        wr_req = 1'b1; wr_addr = 32'h0000_0300; wr_data = 128'h1;
        rd_req = 1'b1; rd_addr = 32'h0000_0400;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        #1;
        chk("mr_arvalid", arvalid, 1'b1);
        chk("mr_awvalid", awvalid, 1'b1);
        @(negedge clk); #1;
        chk("mr_rready", rready, 1'b1);
        rvalid = 1'b1; rdata = 32'hA0; rlast = 1'b0;
        @(negedge clk);
        rdata = 32'hA1;
        @(negedge clk);
        rdata = 32'hA2;
        #2;
        resetn = 1'b0;
        #1;
        chk("mr_rready_rst", rready, 1'b0);
        chk("mr_awvalid_rst", awvalid, 1'b0);
        chk("mr_ret_data_rst", ret_data, 128'd0);
        chk("mr_valids_rst", {arvalid, wvalid, wlast, bready, ret_valid, wr_valid}, 6'd0);
        @(negedge clk);
        rvalid = 1'b0;
        awready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("mr_rd_rdy", rd_rdy, 1'b1);
        chk("mr_wr_rdy", wr_rdy, 1'b1);
        read_line("mr_fresh", 32'h0000_0500, {32'h5D, 32'h5C, 32'h5B, 32'h5A}, 4,
                  {32'h5D, 32'h5C, 32'h5B, 32'h5A}, ra, rv);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
